// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack fetch/execute sequencer.
package hack_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        EXEC   = 3'd5,
        ERROR  = 3'd6
    } seq_state_t;

    // Instruction bit positions: C-instruction flag, a-bit (M operand), d3 (write M)
    localparam int IDX_CI = 15;
    localparam int IDX_A  = 12;
    localparam int IDX_D3 = 3;

endpackage

// File: rtl/hack_bus_timer.sv
// Bus watchdog: counts consecutive unacknowledged request cycles; TIMEOUT=0 disables it.
module hack_bus_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge i_clk) begin
                if (i_rst || i_clear || i_ack) begin
                    r_cnt <= '0;
                end else if (i_req && (r_cnt != LIMIT)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            // Expires on the TIMEOUT-th consecutive waiting cycle
            assign o_expired = i_req && !i_ack && !i_clear && (r_cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/hack_sequencer.sv
// Multi-cycle fetch/execute controller for the Hack CPU datapath.
// Optional macro HACK_SEQ_SINGLE_STEP_EN adds step_i for one-instruction-per-pulse execution.
module hack_sequencer
    import hack_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
`ifdef HACK_SEQ_SINGLE_STEP_EN
    input  logic             step_i,
`endif
    output logic             rom_req_o,
    input  logic             rom_ack_i,
    input  logic [15:0]      rom_data_i,
    output logic [15:0]      instr_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    input  logic             ram_ack_i,
    output logic             mem_latch_o,
    input  logic             en_a_req_i,
    input  logic             en_d_req_i,
    input  logic             load_pc_req_i,
    output logic             en_a_o,
    output logic             en_d_o,
    output logic             load_pc_o,
    output logic             inc_pc_o,
    output logic             busy_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] retired_o
);

    seq_state_t       r_state;
    logic [15:0]      r_instr;
    logic [CNT_W-1:0] r_retired;

    logic w_start;
    logic w_continue;
    logic w_req;
    logic w_ack;
    logic w_expired;
    logic w_ci;
    logic w_a;
    logic w_d3;

`ifdef HACK_SEQ_SINGLE_STEP_EN
    assign w_start    = run_i & step_i;
    assign w_continue = 1'b0;
`else
    assign w_start    = run_i;
    assign w_continue = run_i;
`endif

    assign w_ci = r_instr[IDX_CI];
    assign w_a  = r_instr[IDX_A];
    assign w_d3 = r_instr[IDX_D3];

    // Acks only count while the matching request is up
    assign w_req = rom_req_o | ram_req_o;
    assign w_ack = (rom_req_o & rom_ack_i) | (ram_req_o & ram_ack_i);

    hack_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_req     (w_req),
        .i_ack     (w_ack),
        .i_clear   (~w_req),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) r_state <= FETCH;
                FETCH: begin
                    if (rom_ack_i) begin
                        r_instr <= rom_data_i;
                        r_state <= DECODE;
                    end else if (w_expired) begin
                        r_state <= ERROR;
                    end
                end
                DECODE: begin
                    if (w_ci && w_a)       r_state <= MEM_RD;
                    else if (w_ci && w_d3) r_state <= MEM_WR;
                    else                   r_state <= EXEC;
                end
                MEM_RD: begin
                    if (ram_ack_i)      r_state <= w_d3 ? MEM_WR : EXEC;
                    else if (w_expired) r_state <= ERROR;
                end
                MEM_WR: begin
                    if (ram_ack_i)      r_state <= EXEC;
                    else if (w_expired) r_state <= ERROR;
                end
                EXEC: begin
                    r_retired <= r_retired + CNT_W'(1);
                    r_state   <= w_continue ? FETCH : IDLE;
                end
                ERROR:   r_state <= ERROR;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rom_req_o   = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        mem_latch_o = 1'b0;
        en_a_o      = 1'b0;
        en_d_o      = 1'b0;
        load_pc_o   = 1'b0;
        inc_pc_o    = 1'b0;
        case (r_state)
            FETCH:  rom_req_o = 1'b1;
            MEM_RD: begin
                ram_req_o   = 1'b1;
                mem_latch_o = ram_ack_i;
            end
            MEM_WR: begin
                ram_req_o = 1'b1;
                ram_we_o  = 1'b1;
            end
            EXEC: begin
                en_a_o    = en_a_req_i;
                en_d_o    = en_d_req_i;
                load_pc_o = load_pc_req_i;
                inc_pc_o  = ~load_pc_req_i;
            end
            default: ;
        endcase
    end

    assign busy_o    = (r_state != IDLE) && (r_state != ERROR);
    assign bus_err_o = (r_state == ERROR);
    assign instr_o   = r_instr;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_hack_sequencer.sv
// Directed bench for hack_sequencer (TIMEOUT=4): A/C/jump instructions, run drop, reset, watchdog.
module tb_hack_sequencer;

    logic        clk = 1'b0;
    logic        rst_i, run_i;
    logic        rom_req_o, rom_ack_i;
    logic [15:0] rom_data_i, instr_o;
    logic        ram_req_o, ram_we_o, ram_ack_i, mem_latch_o;
    logic        en_a_req_i, en_d_req_i, load_pc_req_i;
    logic        en_a_o, en_d_o, load_pc_o, inc_pc_o;
    logic        busy_o, bus_err_o;
    logic [15:0] retired_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hack_sequencer #(.CNT_W(16), .TIMEOUT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .run_i         (run_i),
        .rom_req_o     (rom_req_o),
        .rom_ack_i     (rom_ack_i),
        .rom_data_i    (rom_data_i),
        .instr_o       (instr_o),
        .ram_req_o     (ram_req_o),
        .ram_we_o      (ram_we_o),
        .ram_ack_i     (ram_ack_i),
        .mem_latch_o   (mem_latch_o),
        .en_a_req_i    (en_a_req_i),
        .en_d_req_i    (en_d_req_i),
        .load_pc_req_i (load_pc_req_i),
        .en_a_o        (en_a_o),
        .en_d_o        (en_d_o),
        .load_pc_o     (load_pc_o),
        .inc_pc_o      (inc_pc_o),
        .busy_o        (busy_o),
        .bus_err_o     (bus_err_o),
        .retired_o     (retired_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b1; run_i = 1'b0; rom_ack_i = 1'b0; rom_data_i = 16'h0000;
        ram_ack_i = 1'b0; en_a_req_i = 1'b0; en_d_req_i = 1'b0; load_pc_req_i = 1'b0;
        cyc(); cyc();

        // Reset state
        cyc(); rst_i = 1'b0; settle();
        chk("rst_rom_req", rom_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_retired", retired_o, 0);
        chk("rst_bus_err", bus_err_o, 0);

        // A-instruction 0x0005 with immediate ack
        cyc(); run_i = 1'b1; rom_ack_i = 1'b1; rom_data_i = 16'h0005; settle();
        chk("idle_rom_req", rom_req_o, 0);
        cyc(); settle();                                   // FETCH
        chk("a_fetch_req", rom_req_o, 1);
        chk("a_fetch_busy", busy_o, 1);
        cyc(); rom_ack_i = 1'b0; en_a_req_i = 1'b1; settle(); // DECODE
        chk("a_dec_req", rom_req_o, 0);
        chk("a_dec_instr", instr_o, 16'h0005);
        chk("a_dec_en_a", en_a_o, 0);
        cyc(); settle();                                   // EXEC
        chk("a_exec_en_a", en_a_o, 1);
        chk("a_exec_inc", inc_pc_o, 1);
        chk("a_exec_load", load_pc_o, 0);
        chk("a_exec_ret", retired_o, 0);
        cyc(); en_a_req_i = 1'b0; settle();                // FETCH again
        chk("a_next_fetch", rom_req_o, 1);
        chk("a_retired", retired_o, 1);
        chk("a_after_en_a", en_a_o, 0);

        // C-instruction 0xFC08, acks delayed two cycles
        cyc(); settle();
        cyc(); rom_ack_i = 1'b1; rom_data_i = 16'hFC08; settle();
        cyc(); rom_ack_i = 1'b0; settle();                 // DECODE
        chk("c_dec_ram_req", ram_req_o, 0);
        chk("c_dec_instr", instr_o, 16'hFC08);
        cyc(); settle();                                   // MEM_RD wait 1
        chk("c_rd_req", ram_req_o, 1);
        chk("c_rd_we", ram_we_o, 0);
        chk("c_rd_latch0", mem_latch_o, 0);
        cyc(); settle();                                   // MEM_RD wait 2
        cyc(); ram_ack_i = 1'b1; settle();                 // MEM_RD ack
        chk("c_rd_latch", mem_latch_o, 1);
        cyc(); ram_ack_i = 1'b0; settle();                 // MEM_WR
        chk("c_wr_req", ram_req_o, 1);
        chk("c_wr_we", ram_we_o, 1);
        chk("c_wr_latch", mem_latch_o, 0);
        cyc(); settle();
        cyc(); ram_ack_i = 1'b1; settle();
        chk("c_wr_ack_lat", mem_latch_o, 0);
        cyc(); ram_ack_i = 1'b0; settle();                 // EXEC
        chk("c_exec_inc", inc_pc_o, 1);
        chk("c_exec_ramreq", ram_req_o, 0);
        chk("c_exec_ret", retired_o, 1);

        // Jump 0xE307 with load_pc_req_i
        cyc(); rom_ack_i = 1'b1; rom_data_i = 16'hE307; settle();
        chk("c_retired", retired_o, 2);
        cyc(); rom_ack_i = 1'b0; load_pc_req_i = 1'b1; settle(); // DECODE
        chk("j_dec_ram_req", ram_req_o, 0);
        cyc(); settle();                                   // EXEC
        chk("j_exec_load", load_pc_o, 1);
        chk("j_exec_inc", inc_pc_o, 0);
        chk("j_exec_ramreq", ram_req_o, 0);

        // run_i dropped during MEM_WR
        cyc(); load_pc_req_i = 1'b0; rom_ack_i = 1'b1; rom_data_i = 16'hFC08; settle();
        chk("j_retired", retired_o, 3);
        cyc(); rom_ack_i = 1'b0; settle();                 // DECODE
        cyc(); ram_ack_i = 1'b1; settle();                 // MEM_RD ack
        cyc(); run_i = 1'b0; settle();                     // MEM_WR ack
        chk("r_wr_we", ram_we_o, 1);
        cyc(); ram_ack_i = 1'b0; settle();                 // EXEC
        chk("r_exec_inc", inc_pc_o, 1);
        chk("r_exec_busy", busy_o, 1);
        cyc(); settle();                                   // IDLE
        chk("r_idle_busy", busy_o, 0);
        chk("r_idle_req", rom_req_o, 0);
        chk("r_retired", retired_o, 4);
        cyc(); settle();
        chk("r_idle_hold", rom_req_o, 0);

        // Reset during MEM_RD
        cyc(); run_i = 1'b1; settle();
        cyc(); rom_ack_i = 1'b1; rom_data_i = 16'hFC08; settle();
        cyc(); rom_ack_i = 1'b0; settle();                 // DECODE
        cyc(); rst_i = 1'b1; settle();                     // MEM_RD
        chk("x_rd_req", ram_req_o, 1);
        cyc(); settle();
        chk("x_ram_req", ram_req_o, 0);
        chk("x_instr", instr_o, 0);
        chk("x_retired", retired_o, 0);
        chk("x_busy", busy_o, 0);
        rst_i = 1'b0; run_i = 1'b0;

        // Watchdog: rom_ack_i held low with TIMEOUT=4
        cyc(); run_i = 1'b1; settle();
        cyc(); settle(); chk("t_req1", rom_req_o, 1);
        cyc(); settle();
        cyc(); settle();
        cyc(); settle();
        chk("t_req4", rom_req_o, 1);
        chk("t_err_pre", bus_err_o, 0);
        cyc(); rom_ack_i = 1'b1; en_a_req_i = 1'b1; settle();
        chk("t_bus_err", bus_err_o, 1);
        chk("t_rom_req", rom_req_o, 0);
        chk("t_busy", busy_o, 0);
        chk("t_en_a", en_a_o, 0);
        cyc(); settle();
        chk("t_sticky", bus_err_o, 1);
        cyc(); rst_i = 1'b1; run_i = 1'b0; rom_ack_i = 1'b0; en_a_req_i = 1'b0; settle();
        cyc(); settle();
        chk("t_rst_clear", bus_err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
